// File: rtl/ram_loader.sv
// Stream-to-RAM loader: takes an address word, a count word, then count data words, and issues zero-latency RAM writes.
// Define RAM_LOADER_CHECKSUM_EN to add a trailing checksum word that sets o_error on a mismatch.
module ram_loader #(
    parameter  int RAM_DEPTH  = 16,
    parameter  int WIDTH      = 8,
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  mclk_en,
    input  logic                  i_start,
    input  logic                  i_valid,
    input  logic [WIDTH-1:0]      i_data,
    output logic                  o_ready,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic                  o_ram_load_enable,
    output logic [WIDTH-1:0]      o_ram_load_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
`ifdef RAM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    // State entered after the last data word (or a zero count).
`ifdef RAM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_remain;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] w_addr_next;

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]      r_csum;
    logic                  r_error;
    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

    // Explicit wrap so non-power-of-two depths still cycle through 0..RAM_DEPTH-1.
    assign w_addr_next = (r_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);

    assign o_ready           = r_ready;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_ram_address     = r_addr;
    assign o_ram_load_data   = i_data;
    assign o_ram_load_enable = (r_state == S_DATA) & i_valid;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
            r_csum   <= '0;
            r_error  <= 1'b0;
`endif
        end else if (mclk_en) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state <= S_ADDR;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
                        r_csum  <= '0;
                        r_error <= 1'b0;
`endif
                    end
                end
                S_ADDR: begin
                    if (i_valid) begin
                        r_addr  <= i_data[ADDR_WIDTH-1:0];
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (i_valid) begin
                        r_remain <= i_data;
                        if (i_data != '0) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_TAIL;
                            if (S_TAIL == S_DONE) begin
                                r_ready <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (i_valid) begin
                        r_addr   <= w_addr_next;
                        r_remain <= r_remain - WIDTH'(1);
`ifdef RAM_LOADER_CHECKSUM_EN
                        r_csum   <= r_csum + i_data;
`endif
                        if (r_remain == WIDTH'(1)) begin
                            r_state <= S_TAIL;
                            if (S_TAIL == S_DONE) begin
                                r_ready <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
`ifdef RAM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (i_valid) begin
                        r_error <= (i_data != r_csum);
                        r_state <= S_DONE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 16, number of RAM words addressed.
REQ-002 SHALL have parameter WIDTH, default 8, width of stream words and RAM words.
REQ-003 SHALL derive localparam ADDR_WIDTH = $clog2(RAM_DEPTH); not overridable.
REQ-004 mclk  input  1  single clock; all state updates on posedge mclk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mclk_en  input  1  clock enable; state, counters and handshakes advance only when high.
REQ-007 i_start  input  1  request to begin a load session.
REQ-008 i_valid  input  1  stream word present on i_data.
REQ-009 i_data  input  WIDTH  stream word.
REQ-010 o_ready  output  1  loader accepts i_data this cycle.
REQ-011 o_ram_address  output  ADDR_WIDTH  RAM write address.
REQ-012 o_ram_load_enable  output  1  RAM write strobe; the RAM also gates it with mclk_en.
REQ-013 o_ram_load_data  output  WIDTH  RAM write data.
REQ-014 o_busy  output  1  session in progress; CPU is held while high.
REQ-015 o_done  output  1  session complete.
REQ-016 o_error  output  1  checksum mismatch on the last session.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, COUNT, DATA, CSUM, DONE.
REQ-018 A transfer SHALL occur on a posedge where mclk_en & i_valid & o_ready are all high; no state changes otherwise.
REQ-019 o_ready SHALL be high exactly in ADDR, COUNT, DATA and CSUM.
REQ-020 IDLE or DONE with i_start & mclk_en SHALL go to ADDR, clear o_done and o_error, and zero the checksum accumulator; i_start in other states SHALL be ignored.
REQ-021 ADDR transfer SHALL load the address counter from i_data[ADDR_WIDTH-1:0]; upper bits are ignored; next state is COUNT.
REQ-022 COUNT transfer SHALL load a WIDTH-bit remaining counter from i_data.
- If nonzero, next state is DATA.
- If zero, next state is CSUM (macro defined) or DONE (macro undefined), and no RAM write occurs.
REQ-023 o_ram_load_enable SHALL equal (state==DATA) & i_valid, combinationally.
- o_ram_load_data SHALL equal i_data.
- o_ram_address SHALL equal the address counter.
- The RAM write therefore lands on the same enabled edge as the DATA transfer (zero latency).
REQ-024 Each DATA transfer SHALL do all of the following:
- increment the address counter modulo RAM_DEPTH (wraps from RAM_DEPTH-1 to 0);
- decrement the remaining counter;
- add i_data to the checksum modulo 2^WIDTH.
REQ-025 A DATA transfer with remaining==1 SHALL go to CSUM (macro defined) or DONE (macro undefined).
REQ-026 Counts greater than RAM_DEPTH SHALL be legal; later words overwrite earlier ones after wrap.
REQ-027 o_busy SHALL be high in ADDR, COUNT, DATA and CSUM; o_done SHALL be high exactly in DONE.
REQ-028 DONE SHALL hold until i_start; o_error SHALL hold its value through DONE.
REQ-029 i_valid low in any state SHALL stall without side effects; o_ram_load_enable stays 0.

Reset
REQ-030 Reset SHALL force the following, immediately and independently of mclk and mclk_en:
- state = IDLE;
- address counter, remaining counter and checksum = 0;
- o_ready = o_busy = o_done = o_error = o_ram_load_enable = 0;
- o_ram_address = 0.
REQ-031 Reset mid-session SHALL abort with no further RAM writes; words already written stay in RAM.

Configuration
REQ-032 With macro RAM_LOADER_CHECKSUM_EN defined:
- CSUM state exists.
- A CSUM transfer goes to DONE and sets o_error = (i_data != checksum).
REQ-033 Without RAM_LOADER_CHECKSUM_EN:
- CSUM state and checksum accumulator are absent.
- o_error is tied 0.
- The final DATA transfer, or a zero COUNT, goes directly to DONE.

Verification
REQ-034 Reset, then i_start and stream 03,02,AA,BB → RAM[3]=AA, RAM[4]=BB, o_done=1, o_busy=0; with macro, send 65 → o_error=0.
REQ-035 Wrap: stream 0F,03,11,22,33 (RAM_DEPTH=16) → RAM[15]=11, RAM[0]=22, RAM[1]=33.
REQ-036 Stream 05,00 → no o_ram_load_enable pulse; with macro, checksum byte 00 → o_error=0; without macro, DONE follows the COUNT transfer directly.
REQ-037 Stalls: toggle mclk_en and i_valid low between words → identical RAM contents to REQ-034; each word written exactly once.
REQ-038 With macro, stream 00,01,10 then checksum 11 → o_error=1 and RAM[0]=10.
REQ-039 Assert reset after the first DATA word of 00,04,… → state IDLE, o_busy=0, RAM[0] written, RAM[1..3] unchanged.
